// File: rtl/mips_pkg.sv
// =============================================================================
// mips_pkg : opcodes, ALU/select encodings, states and control bundle
// Rev 1.0
// =============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_FUNCT = 3'd5;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXE  = 4'd2,
        S_MEM  = 4'd3,
        S_WB   = 4'd4,
        S_BR   = 4'd5,
        S_JMP  = 4'd6,
        S_HALT = 4'd7
    } state_t;

    typedef struct packed {
        logic       pcwrt;
        logic       branch;
        logic       jump;
        logic       irwrt;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] wbsrc;
        logic       alusrcb;
        logic       extsel;
        logic [2:0] aluop;
        logic       memwrite;
    } ctrl_t;

    // Opcodes that go through the EXE state (R-type, memory and ALU-immediate)
    function automatic logic is_exe_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)    || (op == OP_SW)   ||
               (op == OP_ADDI)  || (op == OP_ADDIU) || (op == OP_ANDI) ||
               (op == OP_ORI)   || (op == OP_SLTI);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_outdec.sv
// =============================================================================
// mc_outdec : combinational decode of {state, opcode, zero} to control outputs
// Rev 1.0
// =============================================================================
`default_nettype none

module mc_outdec
    import mips_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.irwrt = 1'b1;
            end
            S_EXE: begin
                ctrl.alusrcb = (opcode != OP_RTYPE);
                ctrl.extsel  = (opcode == OP_LW)   || (opcode == OP_SW) ||
                               (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                               (opcode == OP_SLTI);
                case (opcode)
                    OP_RTYPE: ctrl.aluop = ALU_FUNCT;
                    OP_ANDI:  ctrl.aluop = ALU_AND;
                    OP_ORI:   ctrl.aluop = ALU_OR;
                    OP_SLTI:  ctrl.aluop = ALU_SLT;
                    default:  ctrl.aluop = ALU_ADD;
                endcase
            end
            S_MEM: begin
                // lw continues to WB, so only sw retires here
                if (opcode == OP_SW) begin
                    ctrl.memwrite = 1'b1;
                    ctrl.pcwrt    = 1'b1;
                end
            end
            S_WB: begin
                ctrl.regwrite = 1'b1;
                ctrl.pcwrt    = 1'b1;
                if (opcode == OP_RTYPE) begin
                    ctrl.regdst = DST_RD;
                end
                if (opcode == OP_LW) begin
                    ctrl.wbsrc = WB_MEM;
                end
            end
            S_BR: begin
                ctrl.aluop   = ALU_SUB;
                ctrl.alusrcb = 1'b0;
                ctrl.pcwrt   = 1'b1;
                ctrl.branch  = ((opcode == OP_BEQ) &&  zero) ||
                               ((opcode == OP_BNE) && !zero);
            end
            S_JMP: begin
                ctrl.jump  = 1'b1;
                ctrl.pcwrt = 1'b1;
                if (opcode == OP_JAL) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.regdst   = DST_RA;
                    ctrl.wbsrc    = WB_PC4;
                end
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// =============================================================================
// mc_control : multi-cycle MIPS main control FSM with retired-instruction count
// Rev 1.0
// =============================================================================
`default_nettype none

module mc_control
    import mips_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111,
    parameter int         CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCwrt,
    output logic             branch,
    output logic             jump,
    output logic             IRwrt,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       WBSrc,
    output logic             ALUSrcB,
    output logic             ExtSel,
    output logic [2:0]       ALUOp,
    output logic             MemWrite,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_retired;
    logic               r_halted;
    ctrl_t              w_dec;
    ctrl_t              w_ctrl;
    logic               w_unused_funct;

    // funct is resolved by the ALU decoder, not by this FSM
    assign w_unused_funct = ^funct;

    mc_outdec u_outdec (
        .state  (r_state),
        .opcode (opcode),
        .zero   (zero),
        .ctrl   (w_dec)
    );

    // Reset low masks every enable and select combinationally, not just at the edge
    assign w_ctrl = reset ? w_dec : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF:  w_next = S_ID;
            S_ID: begin
                if (opcode == HALT_OP) begin
                    w_next = S_HALT;
                end else if (is_exe_op(opcode)) begin
                    w_next = S_EXE;
                end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
                    w_next = S_BR;
                end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
                    w_next = S_JMP;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_EXE:  w_next = is_mem_op(opcode) ? S_MEM : S_WB;
            S_MEM:  w_next = (opcode == OP_LW) ? S_WB : S_IF;
            S_WB:   w_next = S_IF;
            S_BR:   w_next = S_IF;
            S_JMP:  w_next = S_IF;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IF;
            r_retired <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= r_halted | (w_next == S_HALT);
            if (w_ctrl.pcwrt) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign PCwrt    = w_ctrl.pcwrt;
    assign branch   = w_ctrl.branch;
    assign jump     = w_ctrl.jump;
    assign IRwrt    = w_ctrl.irwrt;
    assign RegWrite = w_ctrl.regwrite;
    assign RegDst   = w_ctrl.regdst;
    assign WBSrc    = w_ctrl.wbsrc;
    assign ALUSrcB  = w_ctrl.alusrcb;
    assign ExtSel   = w_ctrl.extsel;
    assign ALUOp    = w_ctrl.aluop;
    assign MemWrite = w_ctrl.memwrite;
    assign halted   = r_halted;
    assign retired  = r_retired;
    assign state    = r_state;

endmodule

`default_nettype wire

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle main control FSM for the MIPS datapath.
- It is the driving end of the PC-update interface. It generates `PCwrt`, `branch` and `jump` for the next-PC unit, plus the instruction-register, register-file, ALU and data-memory enables.
- It sequences each instruction through fetch, decode, execute, memory and write-back.
- It counts retired instructions and stops on a halt opcode.

Parameters:
- `HALT_OP`, `6'b111111`: opcode that halts the core until reset.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `opcode` input 6: `IR[31:26]`; stable from the `ID` state onward.
- `funct` input 6: `IR[5:0]`.
- `zero` input 1: ALU zero flag. Combinational; valid before the falling edge of the `BR` state.
- `PCwrt` output 1: PC write enable to the next-PC unit.
- `branch` output 1: take PC+4+(imm32<<2).
- `jump` output 1: take {PC[31:28], imm26, 00}.
- `IRwrt` output 1: instruction register load.
- `RegWrite` output 1: register-file write.
- `RegDst` output 2: write address select. 0 = rt, 1 = rd, 2 = $31.
- `WBSrc` output 2: write data select. 0 = ALU, 1 = memory, 2 = PC+4.
- `ALUSrcB` output 1: 0 = rt, 1 = extended immediate.
- `ExtSel` output 1: 0 = zero-extend, 1 = sign-extend.
- `ALUOp` output 3: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 by-funct.
- `MemWrite` output 1: data memory write.
- `halted` output 1: sticky halt indication.
- `retired` output `CNT_W`: count of completed instructions.
- `state` output 4: current state encoding, for debug.

Behaviour:
- States: `IF`=0, `ID`=1, `EXE`=2, `MEM`=3, `WB`=4, `BR`=5, `JMP`=6, `HALT`=7.
- Reset, sampled when `reset`=0 at a rising clock edge:
  - state←`IF`, `retired`←0, `halted`←0.
  - While `reset`=0, every write enable (`PCwrt`, `IRwrt`, `RegWrite`, `MemWrite`) and `branch`/`jump` is forced to 0.
  - All selects read 0 during reset.
  - A reset asserted mid-instruction aborts that instruction; `retired` is not incremented.
- Outputs are Moore, decoded from state and `opcode`/`funct`. The exception is `branch`, which also uses `zero`.
- All outputs must be stable before the falling edge, because the next-PC unit samples `branch`/`jump` on the falling edge and loads PC on the next rising edge when `PCwrt`=1.
- `IF`: `IRwrt`=1. Next state is `ID`.
- `ID`: no enables asserted. Next state by opcode:
  - R-type (0), `lw`, `sw`, `addi`, `addiu`, `andi`, `ori`, `slti` → `EXE`.
  - `beq`, `bne` → `BR`.
  - `j`, `jal` → `JMP`.
  - `HALT_OP` or any unlisted opcode → `HALT`.
- `EXE`:
  - `ALUSrcB`=1 for all non-R-type opcodes.
  - `ExtSel`=1 for `lw`/`sw`/`addi`/`addiu`/`slti`; 0 for `andi`/`ori`.
  - `ALUOp`=5 for R-type; otherwise per opcode.
  - Next state is `MEM` for `lw`/`sw`, else `WB`.
- `MEM`:
  - `sw`: `MemWrite`=1 and `PCwrt`=1; next state `IF`.
  - `lw`: no enables; next state `WB`.
- `WB`: `RegWrite`=1 and `PCwrt`=1. Next state `IF`.
  - R-type: `RegDst`=1.
  - `lw`: `WBSrc`=1.
  - Others: `RegDst`=0, `WBSrc`=0.
- `BR`: `ALUOp`=sub, `ALUSrcB`=0, `PCwrt`=1. Next state `IF`.
  - `branch` = (beq & `zero`) | (bne & ~`zero`).
- `JMP`: `jump`=1, `PCwrt`=1. Next state `IF`.
  - For `jal` also: `RegWrite`=1, `RegDst`=2, `WBSrc`=2.
- `branch` and `jump` are never 1 in the same cycle.
- `PCwrt` is exactly one cycle per instruction, in that instruction's final state.
- `retired` increments by 1 on every rising edge where `PCwrt`=1. It wraps modulo 2^`CNT_W`.
- `HALT`: all enables 0, `halted`=1. The FSM stays in `HALT` until reset. `retired` is not incremented for the halt instruction.
- Cycles per instruction: R-type/ALU-immediate 4, `lw` 5, `sw` 4, branches 3, jumps 3.
- The next-PC unit uses an active-high reset; the top level connects it to ~`reset`.

Decomposition:
- Shared package `mips_pkg`:
  - Opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`, `OP_ADDI`, `OP_ADDIU`, `OP_ANDI`, `OP_ORI`, `OP_SLTI`).
  - `ALUOp` encodings.
  - State encodings.
  - `RegDst`/`WBSrc` select encodings.
- One sub-module, `mc_outdec`: pure combinational decode of {state, opcode, zero} to control outputs.
- The FSM register and `retired` counter stay in `mc_control`.

Test Plan:
- Reset held low for 3 cycles, opcode=`lw` → state=0 throughout; all enables 0; `retired`=0. After release, `IRwrt`=1 in the first cycle.
- R-type `add` (opcode 0, funct `0x20`) → state sequence 0,1,2,4. `RegWrite`=1, `RegDst`=1 and `PCwrt`=1 only in cycle 4. `retired` goes 0→1.
- `beq` with `zero`=1 → `branch`=1 and `PCwrt`=1 in `BR`. Repeat with `zero`=0 → `branch`=0, `PCwrt`=1. `bne` gives the inverse. Each takes 3 cycles.
- `lw` then `sw` back-to-back → `lw` takes 5 cycles (`WBSrc`=1 in `WB`). `sw` takes 4 cycles with `MemWrite`=`PCwrt`=1 only in `MEM`. `retired`=2.
- `jal` → `JMP` state with `jump`=1, `RegWrite`=1, `RegDst`=2, `WBSrc`=2, `PCwrt`=1. `branch`=0.
- Opcode `6'b111111` after 2 retired instructions → `HALT` reached after `ID`. `halted`=1, `retired` stays 2 for 10 cycles. Reset then restores state `IF` and `halted`=0.
